// File: rtl/ysyx_25020037_gpr_sched_pkg.sv
// Common types and helpers for the GPR write scheduler / scoreboard.
`include "ysyx_25020037_config.vh"

package ysyx_25020037_gpr_sched_pkg;

   localparam int IDX_W    = `YSYX_25020037_GPR_IDX_W;
   localparam int XLEN     = `YSYX_25020037_XLEN;
   localparam int NREG_DEF = `YSYX_25020037_NREG;

   // One GPR-file write: destination index and value.
   typedef struct packed {
      logic [IDX_W-1:0] addr;
      logic [XLEN-1:0]  data;
   } wr_req_t;

   // Indices outside the implemented register file behave as x0.
   function automatic logic [IDX_W-1:0] eff_idx(input logic [IDX_W-1:0] idx,
                                                 input int               nreg);
      return (int'(idx) < nreg) ? idx : '0;
   endfunction

endpackage

// File: rtl/ysyx_25020037_config.vh
// Shared build configuration for the ysyx_25020037 core: register-file
// geometry used by the GPR scoreboard and its neighbours.
`ifndef YSYX_25020037_CONFIG_VH
`define YSYX_25020037_CONFIG_VH

`define YSYX_25020037_NREG      16
`define YSYX_25020037_GPR_IDX_W 5
`define YSYX_25020037_XLEN      32

`endif

// File: rtl/ysyx_25020037_rr_arb2.sv
// Two-requester round-robin arbiter. req[0]/grant[0] is the writeback unit,
// req[1]/grant[1] is the load unit. After reset the load unit counts as the
// last winner, so the writeback unit wins the first tie.
module ysyx_25020037_rr_arb2
   import ysyx_25020037_gpr_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_ld_q;
   logic last_ld_d;

   // Grant selection: a lone requester always wins, a tie goes to the source
   // that did not win last time.
   always_comb begin
      grant     = req;
      last_ld_d = last_ld_q;
      if (req == 2'b11) begin
         grant = last_ld_q ? 2'b01 : 2'b10;
      end
      if (advance) begin
         last_ld_d = grant[1];
      end
   end

   // Remember which source won the most recent accepted grant.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_ld_q <= 1'b1;
      end else begin
         last_ld_q <= last_ld_d;
      end
   end

endmodule

// File: rtl/ysyx_25020037_gpr_sched.sv
// GPR scoreboard and write-port scheduler. Tracks a pending-write bit per
// GPR, stalls issue on RAW/WAW hazards, merges writeback and load returns
// onto the single register-file write port, and provides a drain sequence
// used ahead of ecall/mret/CSR instructions.
module ysyx_25020037_gpr_sched
   import ysyx_25020037_gpr_sched_pkg::*;
#(
   parameter int NREG = NREG_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [IDX_W-1:0] issue_rs1,
   input  logic [IDX_W-1:0] issue_rs2,
   input  logic [IDX_W-1:0] issue_rd,
   input  logic             issue_we,
   input  logic             wb_valid,
   output logic             wb_ready,
   input  logic [IDX_W-1:0] wb_rd,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [IDX_W-1:0] ld_rd,
   input  logic [XLEN-1:0]  ld_data,
   output logic             gpr_wen,
   output logic [IDX_W-1:0] gpr_waddr,
   output logic [XLEN-1:0]  gpr_wdata,
   input  logic             drain_req,
   output logic             drain_done,
   output logic [NREG-1:0]  busy_mask,
   output logic             err_spurious
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [NREG-1:0] busy_q, busy_d;
   logic            wen_q, wen_d;
   wr_req_t         wr_q, wr_d;
   logic            err_q, err_d;

   logic [1:0]      grant;
   logic            acc;
   wr_req_t         acc_wr;
   logic [NREG-1:0] acc_oh;
   logic [NREG-1:0] clr_oh;
   logic [NREG-1:0] set_oh;
   logic [NREG-1:0] need_oh;
   logic            hazard;

   // One-hot decode of a register index; x0 and out-of-range indices map to
   // an all-zero vector so they can never become busy.
   function automatic logic [NREG-1:0] dec_idx(input logic [IDX_W-1:0] idx);
      logic [NREG-1:0] oh;
      oh = '0;
      for (int i = 1; i < NREG; i++) begin
         if (idx == IDX_W'(i)) begin
            oh[i] = 1'b1;
         end
      end
      return oh;
   endfunction

   ysyx_25020037_rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     ({ld_valid, wb_valid}),
      .advance (acc),
      .grant   (grant)
   );

   // Issue hazard check, write-port acceptance and scoreboard next state.
   always_comb begin
      need_oh = dec_idx(issue_rs1) | dec_idx(issue_rs2);
      if (issue_we) begin
         need_oh = need_oh | dec_idx(issue_rd);
      end
      hazard      = |(busy_q & need_oh);
      issue_ready = (state_q == ST_RUN) && !hazard;

      wb_ready = grant[0];
      ld_ready = grant[1];
      acc      = |grant;

      acc_wr.addr = eff_idx(wb_rd, NREG);
      acc_wr.data = wb_data;
      if (grant[1]) begin
         acc_wr.addr = eff_idx(ld_rd, NREG);
         acc_wr.data = ld_data;
      end
      acc_oh = acc ? dec_idx(acc_wr.addr) : '0;

      // The write registered last cycle commits at this edge and frees its rd.
      clr_oh = wen_q ? dec_idx(wr_q.addr) : '0;
      set_oh = (issue_valid && issue_ready && issue_we) ? dec_idx(issue_rd) : '0;
      // A set can only meet a clear on an unstalled issue, so the set wins.
      busy_d = (busy_q & ~clr_oh) | set_oh;

      err_d = err_q;
      if ((|acc_oh) && !(|(acc_oh & busy_q)) && !(|(acc_oh & clr_oh))) begin
         err_d = 1'b1;
      end

      wen_d = |acc_oh;
      wr_d  = acc ? acc_wr : wr_q;
   end

   // Drain sequencing: stop issuing until every outstanding write has landed.
   always_comb begin
      state_d    = state_q;
      drain_done = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (drain_req) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((busy_q == '0) && !wen_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            drain_done = 1'b1;
            state_d    = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State, scoreboard and registered write port; reset drops any pending write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_RUN;
         busy_q  <= '0;
         wen_q   <= 1'b0;
         wr_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         wen_q   <= wen_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
      end
   end

   assign gpr_wen      = wen_q;
   assign gpr_waddr    = wr_q.addr;
   assign gpr_wdata    = wr_q.data;
   assign busy_mask    = busy_q;
   assign err_spurious = err_q;

endmodule

// File: tb/tb_ysyx_25020037_gpr_sched.sv
// Self-checking bench for the GPR scheduler: directed scenarios followed by
// randomized traffic, all compared against a behavioural scoreboard model.
module tb_ysyx_25020037_gpr_sched;

   localparam int NREG = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            issue_valid, issue_ready, issue_we;
   logic [4:0]      issue_rs1, issue_rs2, issue_rd;
   logic            wb_valid, wb_ready, ld_valid, ld_ready;
   logic [4:0]      wb_rd, ld_rd;
   logic [31:0]     wb_data, ld_data;
   logic            gpr_wen;
   logic [4:0]      gpr_waddr;
   logic [31:0]     gpr_wdata;
   logic            drain_req, drain_done, err_spurious;
   logic [NREG-1:0] busy_mask;

   int checks   = 0;
   int failures = 0;

   // Reference model: pending-write flags, the write awaiting commit,
   // who won the last tie, sticky error and drain phase (0 run, 1 drain, 2 done).
   bit          m_busy [NREG];
   bit          m_pv;
   int          m_pa;
   logic [31:0] m_pd;
   bit          m_last_ld;
   bit          m_err;
   int          m_mode;

   ysyx_25020037_gpr_sched #(.NREG(NREG)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
      .issue_we(issue_we),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
      .drain_req(drain_req), .drain_done(drain_done),
      .busy_mask(busy_mask), .err_spurious(err_spurious)
   );

   initial forever #5 clk = ~clk;

   function automatic int eff(input logic [4:0] i);
      return (int'(i) < NREG) ? int'(i) : 0;
   endfunction

   function automatic logic [31:0] model_mask();
      logic [31:0] r;
      r = '0;
      for (int i = 1; i < NREG; i++) if (m_busy[i]) r[i] = 1'b1;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_we = 1'b0;
      issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
      ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
      drain_req = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      m_pv = 1'b0; m_pa = 0; m_pd = '0;
      m_last_ld = 1'b1; m_err = 1'b0; m_mode = 0;
   endtask

   // Compare every output against the model, then advance model and clock.
   task automatic cycle();
      bit          exp_ir, exp_wr, exp_lr, acc;
      int          a;
      logic [31:0] d, mask;
      #1;
      mask   = model_mask();
      exp_ir = (m_mode == 0) && !m_busy[eff(issue_rs1)] && !m_busy[eff(issue_rs2)]
               && !(issue_we && m_busy[eff(issue_rd)]);
      exp_wr = wb_valid && (!ld_valid || m_last_ld);
      exp_lr = ld_valid && !exp_wr;
      chk("issue_ready", 32'(issue_ready), 32'(exp_ir));
      chk("wb_ready", 32'(wb_ready), 32'(exp_wr));
      chk("ld_ready", 32'(ld_ready), 32'(exp_lr));
      chk("gpr_wen", 32'(gpr_wen), 32'(m_pv));
      if (m_pv) begin
         chk("gpr_waddr", 32'(gpr_waddr), 32'(m_pa));
         chk("gpr_wdata", gpr_wdata, m_pd);
      end
      chk("busy_mask", 32'(busy_mask), mask);
      chk("err_spurious", 32'(err_spurious), 32'(m_err));
      chk("drain_done", 32'(drain_done), 32'(m_mode == 2));

      acc = exp_wr || exp_lr;
      a   = exp_lr ? eff(ld_rd) : eff(wb_rd);
      d   = exp_lr ? ld_data : wb_data;
      if (acc) m_last_ld = exp_lr;
      if (acc && a != 0 && !m_busy[a] && !(m_pv && m_pa == a)) m_err = 1'b1;
      if (m_mode == 0) begin
         if (drain_req) m_mode = 1;
      end else if (m_mode == 1) begin
         if (mask == 0 && !m_pv) m_mode = 2;
      end else begin
         m_mode = 0;
      end
      if (m_pv) m_busy[m_pa] = 1'b0;
      if (issue_valid && exp_ir && issue_we && eff(issue_rd) != 0) m_busy[eff(issue_rd)] = 1'b1;
      m_pv = acc && a != 0;
      m_pa = a;
      m_pd = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_busy", 32'(busy_mask), 32'h0);
      chk("rst_wen", 32'(gpr_wen), 32'h0);
      chk("rst_waddr", 32'(gpr_waddr), 32'h0);
      chk("rst_wdata", gpr_wdata, 32'h0);
      chk("rst_drain_done", 32'(drain_done), 32'h0);
      chk("rst_err", 32'(err_spurious), 32'h0);
      chk("rst_issue_ready", 32'(issue_ready), 32'h1);
   endtask

   initial begin
      int pulses;
      idle();
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Dependent issue stalls until the cycle after the write commits.
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd5;
      cycle();
      idle();
      #1;
      chk("busy_rd5", 32'(busy_mask), 32'h0020);
      issue_valid = 1'b1; issue_rs1 = 5'd5;
      wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234_5678;
      #1;
      chk("stall_rs1", 32'(issue_ready), 32'h0);
      cycle();
      wb_valid = 1'b0;
      #1;
      chk("commit_wen5", 32'(gpr_wen), 32'h1);
      chk("commit_waddr5", 32'(gpr_waddr), 32'h5);
      chk("stall_in_commit", 32'(issue_ready), 32'h0);
      cycle();
      chk("issue_after_clear", 32'(issue_ready), 32'h1);
      cycle();

      // Round-robin tie between wb (rd=3) and ld (rd=4).
      do_reset();
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd3;
      cycle();
      issue_rd = 5'd4;
      cycle();
      idle();
      wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hAAAA_0003;
      ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'hBBBB_0004;
      #1;
      chk("rr0_wb", 32'(wb_ready), 32'h1);
      cycle();
      chk("rr1_ld", 32'(ld_ready), 32'h1);
      chk("rr1_waddr", 32'(gpr_waddr), 32'h3);
      cycle();
      chk("rr2_wb", 32'(wb_ready), 32'h1);
      chk("rr2_waddr", 32'(gpr_waddr), 32'h4);
      cycle();
      idle();
      #1;
      chk("rr3_waddr", 32'(gpr_waddr), 32'h3);
      cycle();

      // Writes to x0 and to out-of-range indices complete silently.
      do_reset();
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
      #1;
      chk("x0_wb_ready", 32'(wb_ready), 32'h1);
      cycle();
      idle();
      #1;
      chk("x0_no_wen", 32'(gpr_wen), 32'h0);
      chk("x0_busy", 32'(busy_mask), 32'h0);
      chk("x0_no_err", 32'(err_spurious), 32'h0);
      ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'h0BAD_F00D;
      cycle();
      idle();
      #1;
      chk("oor_no_wen", 32'(gpr_wen), 32'h0);
      chk("oor_no_err", 32'(err_spurious), 32'h0);
      cycle();

      // Spurious write to idle rd=7 raises a sticky error.
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h7777_7777;
      cycle();
      idle();
      #1;
      chk("spur_set", 32'(err_spurious), 32'h1);
      for (int i = 0; i < 3; i++) cycle();
      chk("spur_sticky", 32'(err_spurious), 32'h1);
      do_reset();

      // Reset in the accept cycle discards the write.
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd6;
      cycle();
      idle();
      wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h6666_6666;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle();
      model_reset();
      #1;
      chk("rst_mid_wen", 32'(gpr_wen), 32'h0);
      chk("rst_mid_busy", 32'(busy_mask), 32'h0);
      cycle();

      // Drain with nothing outstanding reaches DONE two edges later.
      drain_req = 1'b1;
      cycle();
      idle();
      cycle();
      chk("drain_fast_done", 32'(drain_done), 32'h1);
      cycle();
      chk("drain_fast_over", 32'(drain_done), 32'h0);

      // Drain waits for the load write of rd=2, then pulses once.
      do_reset();
      issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd2;
      cycle();
      idle();
      drain_req = 1'b1;
      cycle();
      idle();
      issue_valid = 1'b1;
      #1;
      chk("drain_blocks_issue", 32'(issue_ready), 32'h0);
      cycle();
      ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'h2222_2222;
      cycle();
      idle();
      issue_valid = 1'b1;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (drain_done === 1'b1) pulses++;
         if (i == 4) chk("issue_after_drain", 32'(issue_ready), 32'h1);
         cycle();
      end
      chk("drain_pulse_count", 32'(pulses), 32'h1);

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 120) == 0) do_reset();
         issue_valid = 1'($urandom_range(0, 1));
         issue_we    = 1'($urandom_range(0, 1));
         issue_rs1   = 5'($urandom_range(0, 18));
         issue_rs2   = 5'($urandom_range(0, 18));
         issue_rd    = 5'($urandom_range(0, 18));
         wb_valid    = ($urandom_range(0, 2) == 0);
         wb_rd       = 5'($urandom_range(0, 18));
         wb_data     = $urandom;
         ld_valid    = ($urandom_range(0, 2) == 0);
         ld_rd       = 5'($urandom_range(0, 18));
         ld_data     = $urandom;
         drain_req   = ($urandom_range(0, 24) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_25020037_gpr_sched.md
YSYX_25020037_GPR_SCHED -- requirements
Module: ysyx_25020037_gpr_sched

Interface
REQ-001 SHALL have parameter NREG, default 16, number of architectural GPRs tracked (RV32E).
REQ-002 SHALL have ports: clk  in  1  sole clock; all state changes on posedge.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-low reset.
REQ-004 SHALL have ports: issue_valid in 1 / issue_ready out 1  IDU issue handshake.
REQ-005 SHALL have ports: issue_rs1, issue_rs2, issue_rd  in  5 each  source and destination indices.
REQ-006 SHALL have ports: issue_we  in  1  instruction writes rd.
REQ-007 SHALL have ports: wb_valid in 1 / wb_ready out 1 / wb_rd in 5 / wb_data in 32  EXU/WBU writeback requester.
REQ-008 SHALL have ports: ld_valid in 1 / ld_ready out 1 / ld_rd in 5 / ld_data in 32  LSU load-return requester.
REQ-009 SHALL have ports: gpr_wen out 1 / gpr_waddr out 5 / gpr_wdata out 32  single GPR-file write port.
REQ-010 SHALL have ports: drain_req in 1 / drain_done out 1  pipeline drain for ecall/mret/CSR ops.
REQ-011 SHALL have ports: busy_mask  out  NREG  pending-write bit per GPR.
REQ-012 SHALL have ports: err_spurious  out  1  sticky: write to non-busy GPR.

Function
REQ-013 SHALL track busy[i] for i=1..NREG-1; busy[0] SHALL read 0 always; indices >= NREG SHALL be treated as x0.
REQ-014 SHALL assert issue_ready combinationally when state=RUN and none of busy[rs1], busy[rs2], (issue_we ? busy[rd] : 0) is set.
REQ-015 SHALL, on issue_valid & issue_ready with issue_we and rd!=0, set busy[rd] at that edge.
REQ-016 SHALL arbitrate wb and ld round-robin: when both valid, grant the source not granted last; single valid requester always granted; last-grant resets to ld (wb wins first tie).
REQ-017 SHALL assert wb_ready/ld_ready only for the granted source, at most one per cycle.
REQ-018 SHALL register the granted write: accepted in cycle N -> gpr_wen=1, gpr_waddr, gpr_wdata valid in cycle N+1 for exactly one cycle.
REQ-019 SHALL force gpr_wen=0 for rd=0 (handshake still completes, no busy change).
REQ-020 SHALL clear busy[rd] at the end of cycle N+1 (same edge the GPR file captures data); issue depending on rd SHALL first be accepted in N+2.
REQ-021 SHALL, if set and clear hit the same index at one edge, give clear priority only when the set came from a stalled issue; since REQ-014 stalls on busy rd, set and clear on the same index SHALL never coincide.
REQ-022 SHALL set err_spurious when a write is accepted for rd!=0 whose busy bit is 0 and no clear is pending for it; cleared only by reset.
REQ-023 SHALL implement FSM: RUN -> DRAIN on drain_req; DRAIN -> DONE when busy_mask==0 and no registered write pending; DONE -> RUN after one cycle.
REQ-024 SHALL hold issue_ready=0 in DRAIN and DONE; writeback arbitration SHALL continue in all states.
REQ-025 SHALL assert drain_done=1 only in DONE (one-cycle pulse); drain_req in RUN with busy_mask==0 SHALL reach DONE in 2 cycles.

Reset
REQ-026 SHALL on rst=0 at posedge: state=RUN, busy_mask=0, gpr_wen=0, gpr_waddr=0, gpr_wdata=0, drain_done=0, err_spurious=0, last-grant=ld.
REQ-027 SHALL discard any accepted-but-uncommitted write when reset is asserted mid-operation (gpr_wen=0 next cycle).

Structure
REQ-028 SHALL take NREG, GPR index width (5) and data width (32) from ysyx_25020037_config.vh macros; FSM encodings local.
REQ-029 SHALL place the two-requester round-robin in sub-module ysyx_25020037_rr_arb2 (req[1:0], grant[1:0], advance).

Verification
REQ-030 Issue rd=5 we=1 -> busy_mask=0x0020; issue rs1=5 stalls until cycle after gpr_wen with waddr=5.
REQ-031 wb_valid & ld_valid both held, rd=3/rd=4 -> grants alternate wb,ld,wb; gpr_waddr sequence 3,4,3 one cycle after each grant.
REQ-032 wb write rd=0, data 0xDEADBEEF -> wb_ready=1, gpr_wen stays 0, busy_mask unchanged, err_spurious=0.
REQ-033 Write to rd=7 with busy[7]=0 -> err_spurious=1 next cycle, remains 1 until rst=0.
REQ-034 busy rd=2, drain_req -> issue_ready=0; after ld write rd=2 commits, drain_done pulses exactly one cycle, then issue_ready=1.
REQ-035 rst=0 for one cycle while write pending -> gpr_wen=0, busy_mask=0 next cycle.
